// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: issues 8-byte aligned fetches and buffers (inst0, inst1) pairs for decode.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue is shown to decode in the same cycle.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [63:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic [31:0] inst0_o,
  output logic [31:0] inst1_o,
  output logic [31:0] pc0_o,
  output logic        valid0_o,
  output logic        valid1_o
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic        v0;
    logic        v1;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [31:0]     pc;
  logic [31:0]     req_pc;
  logic            offset;
  logic            req_off;
  logic            inflight;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;

  logic [31:0]     pc_aligned_c;
  logic            req_c;
  logic            resp_ok_c;
  logic            push_c;
  logic            pop_c;
  entry_t          resp_c;
  entry_t          out_c;
  logic            unused_c;

  assign unused_c     = ^redirect_pc_i[1:0];
  assign pc_aligned_c = {pc[31:3], 3'b000};

  // Occupancy uses registered state only, so a pop never frees a slot for a same-cycle request.
  assign req_c       = !rst_i && !redirect_i && ((count + CW'(inflight)) < CW'(DEPTH));
  assign imem_req_o  = req_c;
  assign imem_addr_o = pc_aligned_c;

  assign resp_ok_c = inflight && !rst_i && !redirect_i;
  assign pop_c     = (count != '0) && !stall_i && !redirect_i;

  // Shape the returning packet; an odd-word start moves the lone instruction into slot 0.
  always_comb begin
    resp_c = '{pc: req_pc, inst0: imem_data_i[31:0], inst1: imem_data_i[63:32],
               v0: 1'b1, v1: 1'b1};
    if (req_off) begin
      resp_c = '{pc: req_pc + 32'd4, inst0: imem_data_i[63:32], inst1: NOP,
                 v0: 1'b1, v1: 1'b0};
    end
  end

`ifdef FETCH_BYPASS_EN
  logic byp_c;
  assign byp_c  = resp_ok_c && (count == '0);
  assign push_c = resp_ok_c && !(byp_c && !stall_i);
`else
  assign push_c = resp_ok_c;
`endif

  // Head pair to decode, NOP/invalid when nothing is available.
  always_comb begin
    out_c = '{pc: 32'd0, inst0: NOP, inst1: NOP, v0: 1'b0, v1: 1'b0};
    if (count != '0) begin
      out_c = mem[head];
    end
`ifdef FETCH_BYPASS_EN
    else if (byp_c) begin
      out_c = resp_c;
    end
`endif
  end

  assign inst0_o  = out_c.inst0;
  assign inst1_o  = out_c.inst1;
  assign pc0_o    = out_c.pc;
  assign valid0_o = out_c.v0;
  assign valid1_o = out_c.v1;

  // Fetch PC, in-flight tracking and queue pointers; redirect outranks push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc       <= RESET_PC;
      offset   <= 1'b0;
      req_pc   <= 32'd0;
      req_off  <= 1'b0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      pc       <= {redirect_pc_i[31:3], 3'b000};
      offset   <= redirect_pc_i[2];
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= req_c;
      if (req_c) begin
        pc      <= pc_aligned_c + 32'd8;
        offset  <= 1'b0;
        req_pc  <= pc_aligned_c;
        req_off <= offset;
      end
      if (push_c) tail <= tail + AW'(1);
      if (pop_c)  head <= head + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem[tail] <= resp_c;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table for reset/fill/drain, hand sequences for redirect and reset corners,
// and a scoreboard of expected pairs pushed at request time and popped when decode consumes.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [63:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic [31:0] inst0_o;
  logic [31:0] inst1_o;
  logic [31:0] pc0_o;
  logic        valid0_o;
  logic        valid1_o;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .inst0_o       (inst0_o),
    .inst1_o       (inst1_o),
    .pc0_o         (pc0_o),
    .valid0_o      (valid0_o),
    .valid1_o      (valid1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        v0;
    logic        v1;
    logic [31:0] pc0;
    logic [31:0] i0;
    logic [31:0] i1;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        v1;
  } exp_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [31:0] exp_fpc = RESET_PC;
  logic        exp_off = 1'b0;
  vec_t        tv[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard/memory model for one clock; inputs must already be settled.
  task automatic tick();
    logic        r;
    logic [31:0] a;
    logic [31:0] base;
    exp_t        e;
    if (rst_i || redirect_i) begin
      sb.delete();
      exp_fpc = rst_i ? RESET_PC : {redirect_pc_i[31:3], 3'b000};
      exp_off = rst_i ? 1'b0 : redirect_pc_i[2];
    end else begin
      if (valid0_o && !stall_i) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got pair at pc %h, expected none", pc0_o);
        end else begin
          e = sb.pop_front();
          chk("sb_pc0", pc0_o, e.pc);
          chk("sb_inst0", inst0_o, e.i0);
          chk("sb_inst1", inst1_o, e.i1);
          chk("sb_valid1", 32'(valid1_o), 32'(e.v1));
        end
      end
      if (imem_req_o) begin
        base = {exp_fpc[31:3], 3'b000};
        chk("req_addr", imem_addr_o, base);
        if (exp_off) e = '{pc: base + 32'd4, i0: base + 32'd4, i1: NOP, v1: 1'b0};
        else         e = '{pc: base, i0: base, i1: base + 32'd4, v1: 1'b1};
        sb.push_back(e);
        exp_fpc = base + 32'd8;
        exp_off = 1'b0;
      end
    end
    chk("v1_implies_v0", 32'(valid1_o && !valid0_o), 32'd0);
    r = imem_req_o;
    a = imem_addr_o;
    @(posedge clk);
    #1;
    imem_data_i = r ? {a + 32'd4, a} : 64'hdead_beef_dead_beef;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  NOP,  NOP};
    tv[1]  = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 1'b0, 32'h0,  NOP,  NOP};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 32'h8,  BYP,  BYP,  32'h0,
               BYP ? 32'h0 : NOP, BYP ? 32'h4 : NOP};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h0,  32'h0,  32'h4};
    tv[4]  = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h0,  32'h0,  32'h4};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  32'h0,  32'h4};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  32'h0,  32'h4};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  32'h0,  32'h4};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h8,  32'h8,  32'hc};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 32'h28, 1'b1, 1'b1, 32'h10, 32'h10, 32'h14};
    tv[10] = '{1'b0, 1'b0, 1'b1, 32'h30, 1'b1, 1'b1, 32'h18, 32'h18, 32'h1c};

    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; stall_i = 1'b0;
    imem_data_i = 64'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset release, fill under stall, start draining
    for (int i = 0; i < 11; i++) begin
      rst_i   = tv[i].rst;
      stall_i = tv[i].stall;
      #1;
      chk($sformatf("vec%0d_req", i), 32'(imem_req_o), 32'(tv[i].req));
      if (tv[i].req) chk($sformatf("vec%0d_addr", i), imem_addr_o, tv[i].addr);
      chk($sformatf("vec%0d_v0", i), 32'(valid0_o), 32'(tv[i].v0));
      chk($sformatf("vec%0d_v1", i), 32'(valid1_o), 32'(tv[i].v1));
      chk($sformatf("vec%0d_pc0", i), pc0_o, tv[i].pc0);
      chk($sformatf("vec%0d_inst0", i), inst0_o, tv[i].i0);
      chk($sformatf("vec%0d_inst1", i), inst1_o, tv[i].i1);
      tick();
    end

    // Steady state: one pair per cycle
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("steady_v0", 32'(valid0_o), 32'd1);
      tick();
    end

    // Long stall: exactly DEPTH buffered, head stable, requests blocked
    stall_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("stall_head_pc", pc0_o, 32'h60);
      tick();
    end
    #1;
    chk("full_req", 32'(imem_req_o), 32'd0);
    chk("full_entries", 32'(sb.size()), 32'(DEPTH));
    stall_i = 1'b0;
    run(DEPTH + 3);

    // Redirect to an odd word while full
    stall_i = 1'b1;
    run(6);
    redirect_i = 1'b1; redirect_pc_i = 32'h104;
    #1;
    chk("redir_req", 32'(imem_req_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("redir_r1_v0", 32'(valid0_o), 32'd0);
    chk("redir_r1_req", 32'(imem_req_o), 32'd1);
    chk("redir_r1_addr", imem_addr_o, 32'h100);
    tick();
    #1;
    chk("redir_r2_v0", 32'(valid0_o), 32'(BYP));
    tick();
    #1;
    chk("redir_r3_v0", 32'(valid0_o), 32'd1);
    chk("redir_r3_pc0", pc0_o, 32'h104);
    chk("redir_r3_inst0", inst0_o, 32'h104);
    chk("redir_r3_v1", 32'(valid1_o), 32'd0);
    chk("redir_r3_inst1", inst1_o, NOP);
    tick();
    stall_i = 1'b0;
    run(6);

    // Redirect in the cycle after a request squashes that response
    #1;
    chk("sq_req", 32'(imem_req_o), 32'd1);
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    run(1);
    redirect_i = 1'b0;
    #1;
    chk("sq_r1_v0", 32'(valid0_o), 32'd0);
    tick();
    #1;
    chk("sq_r2_v0", 32'(valid0_o), 32'(BYP));
    chk("sq_r2_pc0", pc0_o, BYP ? 32'h200 : 32'h0);
    tick();
    #1;
    chk("sq_r3_v0", 32'(valid0_o), 32'd1);
    chk("sq_r3_pc0", pc0_o, BYP ? 32'h208 : 32'h200);
    tick();
    run(5);

    // Reset mid-stream with a response in flight
    #1;
    chk("rst_pre_req", 32'(imem_req_o), 32'd1);
    tick();
    rst_i = 1'b1;
    run(1);
    rst_i = 1'b0;
    #1;
    chk("rst_v0", 32'(valid0_o), 32'd0);
    chk("rst_v1", 32'(valid1_o), 32'd0);
    chk("rst_inst0", inst0_o, NOP);
    chk("rst_inst1", inst1_o, NOP);
    chk("rst_pc0", pc0_o, 32'h0);
    chk("rst_req", 32'(imem_req_o), 32'd1);
    chk("rst_addr", imem_addr_o, RESET_PC);
    tick();
    run(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Dual-issue instruction fetch queue that produces the instruction pairs consumed by the decode stage. It generates 8-byte-aligned fetch addresses to instruction memory, captures 64-bit fetch packets, buffers them as (inst0, inst1) pairs with per-slot valid bits, and presents the oldest pair to decode. It sits between instruction memory and decode, absorbing decode stalls and discarding wrong-path fetches on a redirect.

## Interface
- DEPTH, 4, number of pair entries in the queue (power of two, ≥2)
- RESET_PC, 32'h00000000, first fetch address after reset (8-byte aligned)

- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- imem_req_o  output  1  fetch request this cycle
- imem_addr_o  output  32  fetch address, bits [2:0] always 0
- imem_data_i  input  64  fetch packet, fixed 1-cycle latency after request; [31:0] = word at addr, [63:32] = word at addr+4
- redirect_i  input  1  flush and restart fetch (branch/jump resolved)
- redirect_pc_i  input  32  restart PC, bits [1:0] ignored
- stall_i  input  1  decode cannot accept the head pair this cycle
- inst0_o  output  32  head slot-0 instruction
- inst1_o  output  32  head slot-1 instruction
- pc0_o  output  32  PC of inst0_o; inst1_o is at pc0_o+4
- valid0_o  output  1  inst0_o valid
- valid1_o  output  1  inst1_o valid

## Operation
- State: fetch PC register, align-offset bit for next request, in-flight flag, circular queue (head, tail, count) of entries {pc, inst0, inst1, v0, v1}.
- Request: imem_req_o = !rst_i && !redirect_i && (count + inflight) < DEPTH. imem_addr_o = {pc[31:3], 3'b000}. On request, pc <= {pc[31:3],3'b000} + 8, offset <= 0, inflight <= 1; otherwise inflight <= 0.
- Response: cycle after a request (unless squashed), packet written at tail. Offset 0: entry {pc, data[31:0], data[63:32], 1, 1}. Offset 1 (redirect to pc[2]=1): entry {pc+4, data[63:32], 32'h00000013, 1, 0} — sole instruction moved to slot 0.
- Pop: head consumed when count>0 and !stall_i. Pop and push may occur in the same cycle; count unchanged.
- Outputs: head entry when count>0; else inst0_o = inst1_o = 32'h00000013 (NOP), pc0_o = 0, valid0_o = valid1_o = 0. valid1_o implies valid0_o.
- Redirect: queue cleared (count, head, tail to 0), in-flight response arriving next cycle discarded, pc <= {redirect_pc_i[31:3],3'b000}, offset <= redirect_pc_i[2]. No request in redirect cycle; first new-path request the following cycle.

## Timing
- Reset: imem_req_o=0, valid0_o=valid1_o=0, inst0_o=inst1_o=32'h00000013, pc0_o=0, pc=RESET_PC, queue empty, inflight=0.
- First cycle after rst_i deasserts (N): request at RESET_PC. Data at N+1; entry visible at outputs N+2 (without bypass).
- Redirect at cycle R: request at R+1, outputs valid at R+3 (R+2 with bypass). Outputs invalid at R+1.
- Full: count+inflight = DEPTH blocks requests; never overflow. Pop does not unblock request in same cycle (count+inflight evaluated on registered state).
- Empty: outputs NOP/invalid; stall_i ignored.
- Redirect same cycle as pop, push, or stall: redirect wins; all cleared.
- rst_i mid-operation: same as reset; in-flight response discarded.
- Steady state, no stalls: one pair per cycle.

## Configuration
- FETCH_BYPASS_EN defined: when queue empty (count=0) and a non-squashed response arrives, entry driven combinationally to outputs that cycle; if !stall_i it is consumed and not written; if stall_i it is also written at tail. Latency memory→decode 1 cycle.
- Undefined: responses always written to queue; outputs purely registered-state driven; latency 2 cycles.

## Test plan
- Reset release, RESET_PC=0, memory returns {addr+4, addr}, stall_i=0 -> requests 0x0,0x8,0x10…; outputs from N+2: pc0_o=0, inst0_o=0x0, inst1_o=0x4, both valid; then pc0_o=0x8 next cycle.
- stall_i held high 10 cycles -> exactly DEPTH entries buffered, imem_req_o low after fill, head pair stable; release -> DEPTH pairs drain in order, no duplicates/gaps.
- redirect_i with redirect_pc_i=0x104 while full -> outputs invalid next cycle, request addr 0x100, entry pc0_o=0x104, inst0_o=word@0x104, valid1_o=0, inst1_o=0x00000013.
- Redirect in cycle after a request -> that response discarded; no pair from old path reaches outputs.
- rst_i asserted mid-stream with inflight=1 -> all outputs reset values next cycle, next request at RESET_PC.
- With FETCH_BYPASS_EN, empty queue, response at cycle N -> valid0_o=1 at N; without it valid0_o=1 at N+1.
